ir_nec_decoder: RTL



---
 rtl/ir_nec_decoder.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ir_nec_decoder.sv
// NEC IR remote decoder: synchronizes the receiver pin, times bursts/spaces in
// microseconds and reports validated address/command frames and repeat codes.
module ir_nec_decoder #(
  parameter int unsigned sys_clk_freq = 100_000_000,
  parameter int unsigned timeout_us   = 12_000
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       ir_rx,
  output logic [7:0] addr,
  output logic [7:0] cmd,
  output logic       frame_valid,
  output logic       repeat_valid,
  output logic       err,
  output logic       busy
);

  localparam int unsigned PRESC = sys_clk_freq / 1_000_000;
  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
  // The edge cycle itself counts as the first tick, so an interval of N us reads as N.
  localparam logic [PW-1:0] PRESC_START = (PRESC == 1) ? PW'(0) : PW'(1);
  localparam logic [13:0]   US_START    = (PRESC == 1) ? 14'd1 : 14'd0;
  localparam logic [13:0]   US_MAX      = 14'h3FFF;
  localparam logic [13:0]   US_TIMEOUT  = 14'(timeout_us);

  typedef enum logic [2:0] {
    IDLE, LEAD_BURST, LEAD_SPACE, BIT_BURST, BIT_SPACE, REPEAT_BURST
  } state_t;

  logic          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic          fall_q, fall_d, rise_q, rise_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [13:0]   us_q, us_d;
  state_t        state_q, state_d;
  logic [31:0]   shreg_q, shreg_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic          have_frame_q, have_frame_d;
  logic [7:0]    addr_q, addr_d, cmd_q, cmd_d;
  logic          fv_q, fv_d, rv_q, rv_d, err_q, err_d;
  logic          edge_seen;

  function automatic logic in_win(input logic [13:0] v, input logic [13:0] lo,
                                  input logic [13:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  always_comb begin
    sync1_d   = ir_rx;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    fall_d    = prev_q & ~sync2_q;
    rise_d    = ~prev_q & sync2_q;
    edge_seen = fall_q | rise_q;

    presc_d = presc_q;
    us_d    = us_q;
    if (edge_seen) begin
      presc_d = PRESC_START;
      us_d    = US_START;
    end else if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      us_d    = (us_q == US_MAX) ? us_q : us_q + 14'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    have_frame_d = have_frame_q;
    addr_d       = addr_q;
    cmd_d        = cmd_q;
    fv_d         = 1'b0;
    rv_d         = 1'b0;
    err_d        = 1'b0;

    unique case (state_q)
      IDLE: if (fall_q) state_d = LEAD_BURST;
      LEAD_BURST:
        if (rise_q) state_d = in_win(us_q, 14'd8000, 14'd10000) ? LEAD_SPACE : IDLE;
      LEAD_SPACE:
        if (fall_q) begin
          if (in_win(us_q, 14'd4000, 14'd5000)) begin
            state_d   = BIT_BURST;
            bit_cnt_d = '0;
          end else if (in_win(us_q, 14'd2000, 14'd2500)) begin
            state_d = REPEAT_BURST;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      BIT_BURST:
        if (rise_q) begin
          if (!in_win(us_q, 14'd400, 14'd700)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (bit_cnt_q < 6'd32) begin
            state_d = BIT_SPACE;
          end else begin
            state_d = IDLE;
            if (shreg_q[15:8] == ~shreg_q[7:0] && shreg_q[31:24] == ~shreg_q[23:16]) begin
              addr_d       = shreg_q[7:0];
              cmd_d        = shreg_q[23:16];
              fv_d         = 1'b1;
              have_frame_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      BIT_SPACE:
        if (fall_q) begin
          if (in_win(us_q, 14'd400, 14'd700) || in_win(us_q, 14'd1400, 14'd1900)) begin
            shreg_d   = {in_win(us_q, 14'd1400, 14'd1900), shreg_q[31:1]};
            bit_cnt_d = bit_cnt_q + 6'd1;
            state_d   = BIT_BURST;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      REPEAT_BURST:
        if (rise_q) begin
          state_d = IDLE;
          if (in_win(us_q, 14'd400, 14'd700)) rv_d = have_frame_q;
          else err_d = 1'b1;
        end
      default: state_d = IDLE;
    endcase

    // A stalled line aborts the frame; an edge in the same cycle takes priority.
    if (state_q != IDLE && !edge_seen && us_q >= US_TIMEOUT) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end

    if (err_d) have_frame_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      fall_q       <= 1'b0;
      rise_q       <= 1'b0;
      presc_q      <= '0;
      us_q         <= '0;
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      have_frame_q <= 1'b0;
      addr_q       <= '0;
      cmd_q        <= '0;
      fv_q         <= 1'b0;
      rv_q         <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      fall_q       <= fall_d;
      rise_q       <= rise_d;
      presc_q      <= presc_d;
      us_q         <= us_d;
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      have_frame_q <= have_frame_d;
      addr_q       <= addr_d;
      cmd_q        <= cmd_d;
      fv_q         <= fv_d;
      rv_q         <= rv_d;
      err_q        <= err_d;
    end
  end

  assign addr         = addr_q;
  assign cmd          = cmd_q;
  assign frame_valid  = fv_q;
  assign repeat_valid = rv_q;
  assign err          = err_q;
  assign busy         = (state_q != IDLE);

endmodule
